// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller: funct3
// encodings, controller states, default tag width and access legality.
package lsu_mem_ctrl_pkg;

    localparam int LSU_TAG_W = 4;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RD,
        S_LD_RSP,
        S_ST_RD,
        S_ST_WR,
        S_ERR
    } lsu_state_t;

    // True when the access cannot be performed: unknown width, unsigned
    // store, or a halfword/word that does not sit on its natural boundary.
    function automatic logic access_bad(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (funct3)
            F3_LB:   bad = 1'b0;
            F3_LH:   bad = addr_lo[0];
            F3_LW:   bad = (addr_lo != 2'b00);
            F3_LBU:  bad = is_store;
            F3_LHU:  bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: load extract/extend, store byte/half merge into
// the old RAM word, and detection of misaligned or illegal accesses.
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic        chk_is_store,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_addr_lo,
    output logic        chk_bad,
    input  logic [2:0]  op_funct3,
    input  logic [1:0]  op_addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign chk_bad = access_bad(chk_is_store, chk_funct3, chk_addr_lo);

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        ld_data  = 32'h0;
        case (op_addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = op_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op_funct3)
            F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   ld_data = rdata;
            F3_LBU:  ld_data = {24'h0, byte_sel};
            F3_LHU:  ld_data = {16'h0, half_sel};
            default: ld_data = 32'h0;
        endcase
    end

    // Overlay the store byte/half onto the old word; a full word replaces it.
    always_comb begin
        st_word = rdata;
        case (op_funct3)
            F3_SB: begin
                case (op_addr_lo)
                    2'd0:    st_word[7:0]   = wdata[7:0];
                    2'd1:    st_word[15:8]  = wdata[7:0];
                    2'd2:    st_word[23:16] = wdata[7:0];
                    default: st_word[31:24] = wdata[7:0];
                endcase
            end
            F3_SH: begin
                if (op_addr_lo[1]) begin
                    st_word[31:16] = wdata[15:0];
                end else begin
                    st_word[15:0] = wdata[15:0];
                end
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory-access initiator: one request at a time, word RAM
// access with read-modify-write for sub-word stores, load results on the CDB.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int TAG_W  = LSU_TAG_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cdb_valid,
    input  logic              cdb_ready,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [31:0]       cdb_data,
    output logic              cdb_exc,
    output logic              st_done,
    output logic [TAG_W-1:0]  st_tag,
    output logic              st_exc
);

    lsu_state_t state, next_state;

    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [TAG_W-1:0]  tag_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wword_q;
    logic [31:0]       ld_data_q;
    logic              ld_exc_q;

    logic              accept;
    logic              req_bad;
    logic [ADDR_W-1:0] req_aligned;
    logic [31:0]       ld_ext;
    logic [31:0]       st_merged;

    assign req_ready   = (state == S_IDLE) && !flush && !rst;
    assign accept      = req_valid && req_ready;
    assign req_aligned = {req_addr[ADDR_W-1:2], 2'b00};

    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wword_q;

    lsu_lane_align u_align (
        .chk_is_store (req_is_store),
        .chk_funct3   (req_funct3),
        .chk_addr_lo  (req_addr[1:0]),
        .chk_bad      (req_bad),
        .op_funct3    (funct3_q),
        .op_addr_lo   (addr_lo_q),
        .rdata        (mem_rdata),
        .wdata        (wdata_q),
        .ld_data      (ld_ext),
        .st_word      (st_merged)
    );

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state strobes; flush only affects loads.
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_data   = 32'h0;
        cdb_exc    = 1'b0;
        st_done    = 1'b0;
        st_tag     = '0;
        st_exc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        next_state = S_ERR;
                    end else if (!req_is_store) begin
                        next_state = S_LD_RD;
                    end else if (req_funct3 == F3_SW) begin
                        next_state = S_ST_WR;
                    end else begin
                        next_state = S_ST_RD;
                    end
                end
            end
            S_LD_RD: begin
                next_state = flush ? S_IDLE : S_LD_RSP;
            end
            S_LD_RSP: begin
                cdb_valid = 1'b1;
                cdb_tag   = tag_q;
                cdb_data  = ld_data_q;
                cdb_exc   = ld_exc_q;
                if (flush || cdb_ready) begin
                    next_state = S_IDLE;
                end
            end
            S_ST_RD: begin
                next_state = S_ST_WR;
            end
            S_ST_WR: begin
                mem_we     = 1'b1;
                st_done    = 1'b1;
                st_tag     = tag_q;
                next_state = S_IDLE;
            end
            S_ERR: begin
                if (is_store_q) begin
                    st_done    = 1'b1;
                    st_tag     = tag_q;
                    st_exc     = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = flush ? S_IDLE : S_LD_RSP;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Hold the accepted request for the duration of the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 32'h0;
            tag_q      <= '0;
        end else if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            wdata_q    <= req_wdata;
            tag_q      <= req_tag;
        end
    end

    // RAM address/data registers; they only move for accesses that touch RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
            waddr_q <= '0;
            wword_q <= 32'h0;
        end else begin
            if (accept && !req_bad) begin
                if (!req_is_store) begin
                    raddr_q <= req_aligned;
                end else begin
                    waddr_q <= req_aligned;
                    if (req_funct3 == F3_SW) begin
                        wword_q <= req_wdata;
                    end else begin
                        raddr_q <= req_aligned;
                    end
                end
            end
            if (state == S_ST_RD) begin
                wword_q <= st_merged;
            end
        end
    end

    // Load result register, filled from the RAM read or forced to an exception.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_data_q <= 32'h0;
            ld_exc_q  <= 1'b0;
        end else if (state == S_LD_RD) begin
            ld_data_q <= ld_ext;
            ld_exc_q  <= 1'b0;
        end else if (state == S_ERR && !is_store_q) begin
            ld_data_q <= 32'h0;
            ld_exc_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: word RAM model, scoreboard of expected CDB
// results, store completions and RAM writes, plus directed timing checks.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    localparam int TAG_W  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cdb_valid;
    logic              cdb_ready;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;
    logic              cdb_exc;
    logic              st_done;
    logic [TAG_W-1:0]  st_tag;
    logic              st_exc;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             exc;
    } cdb_exp_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             exc;
    } st_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    cdb_exp_t cdb_q[$];
    st_exp_t  st_q[$];
    wr_exp_t  wr_q[$];

    int errors = 0;
    int checks = 0;

    logic [31:0] ram       [0:1023];
    logic [31:0] model_mem [0:1023];

    lsu_mem_ctrl #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_tag      (req_tag),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cdb_valid    (cdb_valid),
        .cdb_ready    (cdb_ready),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_exc      (cdb_exc),
        .st_done      (st_done),
        .st_tag       (st_tag),
        .st_exc       (st_exc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int idx);
        if (idx == 64) return 32'h8899AABB;
        return 32'h80DE0000 ^ (32'(idx) * 32'h00010101);
    endfunction

    // Legality written as the list of accepted forms.
    function automatic logic modelBad(input logic st, input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        if (st) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001 && !lo[0]) || (f3 == 3'b010 && lo == 2'b00);
        end else begin
            ok = (f3 == 3'b000) || (f3 == 3'b100) ||
                 ((f3 == 3'b001 || f3 == 3'b101) && !lo[0]) || (f3 == 3'b010 && lo == 2'b00);
        end
        return !ok;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] sh;
        sh = word >> (8 * lo);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] mask;
        if (f3 == 3'b000)      mask = 32'h000000FF << (8 * lo);
        else if (f3 == 3'b001) mask = 32'h0000FFFF << (8 * lo);
        else                   mask = 32'hFFFFFFFF;
        return (old & ~mask) | ((wd << (8 * lo)) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Push the expected outcome (when the request will complete normally),
    // offer the request and return at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [TAG_W-1:0] tag,
                                 input bit expect_result);
        int          idx;
        int          n;
        logic        bad;
        logic [31:0] nw;
        idx = int'(addr[11:2]);
        bad = modelBad(st, f3, addr[1:0]);
        if (expect_result) begin
            if (!st) begin
                cdb_q.push_back('{tag: tag, data: (bad ? 32'h0 : modelLoad(model_mem[idx], addr[1:0], f3)), exc: bad});
            end else begin
                if (!bad) begin
                    nw = modelStore(model_mem[idx], wd, addr[1:0], f3);
                    model_mem[idx] = nw;
                    wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: nw});
                end
                st_q.push_back('{tag: tag, exc: bad});
            end
        end
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        req_tag      = tag;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("req_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((cdb_q.size() != 0 || st_q.size() != 0 || wr_q.size() != 0 || !req_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", {31'b0, (n < 100)}, 32'd1);
    endtask

    task automatic nextCycle();
        @(posedge clk); #1;
    endtask

    // RAM model: combinational read with same-cycle write forwarding.
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = initWord(i);
    end

    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr[11:2]] <= mem_wdata;
    end

    assign mem_rdata = (mem_we && mem_waddr[11:2] == mem_raddr[11:2]) ? mem_wdata : ram[mem_raddr[11:2]];

    // Scoreboard: compare every DUT-produced event with the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (cdb_valid && cdb_ready) begin
                if (cdb_q.size() == 0) begin
                    checkOutput("cdb_unexpected", 32'd1, 32'd0);
                end else begin
                    cdb_exp_t e;
                    e = cdb_q.pop_front();
                    checkOutput("cdb_tag", {28'b0, cdb_tag}, {28'b0, e.tag});
                    checkOutput("cdb_data", cdb_data, e.data);
                    checkOutput("cdb_exc", {31'b0, cdb_exc}, {31'b0, e.exc});
                end
            end
            if (st_done) begin
                if (st_q.size() == 0) begin
                    checkOutput("st_unexpected", 32'd1, 32'd0);
                end else begin
                    st_exp_t s;
                    s = st_q.pop_front();
                    checkOutput("st_tag", {28'b0, st_tag}, {28'b0, s.tag});
                    checkOutput("st_exc", {31'b0, st_exc}, {31'b0, s.exc});
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checkOutput("we_unexpected", 32'd1, 32'd0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    checkOutput("wr_addr", mem_waddr, w.addr);
                    checkOutput("wr_data", mem_wdata, w.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = initWord(i);
        rst          = 1'b1;
        flush        = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_tag      = '0;
        cdb_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_cdb_valid", {31'b0, cdb_valid}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_st_done", {31'b0, st_done}, 32'd0);
        checkOutput("rst_raddr", mem_raddr, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        nextCycle();

        // LB sign-extended, result in cycle 2
        applyStimulus(1'b0, F3_LB, 32'h101, 32'h0, 4'd3, 1'b1);
        @(negedge clk);
        checkOutput("lb_c1_raddr", mem_raddr, 32'h100);
        checkOutput("lb_c1_valid", {31'b0, cdb_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lb_c2_valid", {31'b0, cdb_valid}, 32'd1);
        checkOutput("lb_c2_data", cdb_data, 32'hFFFFFFAA);
        nextCycle();

        // LBU zero-extended
        applyStimulus(1'b0, F3_LBU, 32'h101, 32'h0, 4'd4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("lbu_data", cdb_data, 32'h000000AA);
        nextCycle();

        // SH read-modify-write
        applyStimulus(1'b1, F3_SH, 32'h102, 32'h00001234, 4'd5, 1'b1);
        @(negedge clk);
        checkOutput("sh_c1_we", {31'b0, mem_we}, 32'd0);
        checkOutput("sh_c1_raddr", mem_raddr, 32'h100);
        @(negedge clk);
        checkOutput("sh_c2_we", {31'b0, mem_we}, 32'd1);
        checkOutput("sh_c2_wdata", mem_wdata, 32'h1234AABB);
        checkOutput("sh_c2_done", {31'b0, st_done}, 32'd1);
        nextCycle();

        applyStimulus(1'b0, F3_LW, 32'h100, 32'h0, 4'd1, 1'b1);
        applyStimulus(1'b0, F3_LHU, 32'h102, 32'h0, 4'd2, 1'b1);
        applyStimulus(1'b0, F3_LH, 32'h100, 32'h0, 4'd2, 1'b1);
        drain();

        // SW then immediate LW of the same word
        applyStimulus(1'b1, F3_SW, 32'h200, 32'hDEADBEEF, 4'd6, 1'b1);
        @(negedge clk);
        checkOutput("sw_c1_we", {31'b0, mem_we}, 32'd1);
        checkOutput("sw_c1_ready", {31'b0, req_ready}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, F3_LW, 32'h200, 32'h0, 4'd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("lw_after_sw", cdb_data, 32'hDEADBEEF);
        nextCycle();

        // Misaligned load and store
        applyStimulus(1'b0, F3_LW, 32'h102, 32'h0, 4'd8, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("lw_mis_exc", {31'b0, cdb_exc}, 32'd1);
        checkOutput("lw_mis_data", cdb_data, 32'h0);
        nextCycle();
        applyStimulus(1'b1, F3_SH, 32'h103, 32'h0000BEEF, 4'd9, 1'b1);
        @(negedge clk);
        checkOutput("sh_mis_exc", {31'b0, st_exc}, 32'd1);
        checkOutput("sh_mis_we", {31'b0, mem_we}, 32'd0);
        nextCycle();

        // Illegal funct3
        applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 4'd10, 1'b1);
        applyStimulus(1'b1, 3'b100, 32'h100, 32'h55, 4'd11, 1'b1);
        drain();

        // CDB stall for several cycles, then flush in cycle 4
        cdb_ready = 1'b0;
        applyStimulus(1'b0, F3_LW, 32'h200, 32'h0, 4'd10, 1'b0);
        @(negedge clk);
        nextCycle();
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'b0, cdb_valid}, 32'd1);
            checkOutput("stall_tag", {28'b0, cdb_tag}, 32'd10);
            checkOutput("stall_data", cdb_data, 32'hDEADBEEF);
            checkOutput("stall_ready", {31'b0, req_ready}, 32'd0);
            nextCycle();
        end
        flush = 1'b1;
        @(negedge clk);
        checkOutput("stall_c4_valid", {31'b0, cdb_valid}, 32'd1);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid", {31'b0, cdb_valid}, 32'd0);
        checkOutput("flush_idle", {31'b0, req_ready}, 32'd1);
        nextCycle();
        cdb_ready = 1'b1;

        // Flush coincident with the handshake still delivers the result
        applyStimulus(1'b0, F3_LW, 32'h200, 32'h0, 4'd11, 1'b1);
        nextCycle();
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_hs_valid", {31'b0, cdb_valid}, 32'd1);
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_hs_after", {31'b0, cdb_valid}, 32'd0);
        nextCycle();

        // Flush during the load read kills it
        applyStimulus(1'b0, F3_LW, 32'h100, 32'h0, 4'd12, 1'b0);
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_rd_valid", {31'b0, cdb_valid}, 32'd0);
        checkOutput("flush_rd_ready", {31'b0, req_ready}, 32'd1);
        nextCycle();

        // Flush during a store read is ignored
        applyStimulus(1'b1, F3_SB, 32'h203, 32'h00000055, 4'd13, 1'b1);
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_st_we", {31'b0, mem_we}, 32'd1);
        checkOutput("flush_st_wdata", mem_wdata, 32'h55ADBEEF);
        nextCycle();
        drain();

        // Asynchronous reset during the read of an SB
        applyStimulus(1'b1, F3_SB, 32'h100, 32'h000000EE, 4'd14, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_we", {31'b0, mem_we}, 32'd0);
        checkOutput("arst_raddr", mem_raddr, 32'h0);
        checkOutput("arst_waddr", mem_waddr, 32'h0);
        checkOutput("arst_done", {31'b0, st_done}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        checkOutput("arst_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) nextCycle();
        checkOutput("arst_ram", ram[64], model_mem[64]);

        // Mixed random traffic
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          32'h300 + 32'($urandom_range(0, 63)), $urandom, 4'(i), 1'b1);
        end
        drain();
        for (int i = 192; i < 208; i++) begin
            checkOutput("ram_final", ram[i], model_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Memory-access initiator between the load/store buffer and the word-organised data RAM.
- Accepts one load or committed store at a time and drives the RAM read/write ports.
- Performs read-modify-write for SB/SH, because the RAM writes whole words only.
- Extracts and extends LB/LH/LBU/LHU/LW data and returns load results on the CDB with a valid/ready handshake.

Parameters:
- TAG_W, 4, width of ROB/RS tag carried with each request.
- ADDR_W, 32, byte address width; RAM word index is addr[ADDR_W-1:2].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  mispredict flush; kills an in-flight load, never a store.
- req_valid  in  1  request offered by load/store buffer.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (low bits used for B/H).
- req_tag  in  TAG_W  destination/ROB tag.
- mem_raddr  out  ADDR_W  RAM read address, word aligned.
- mem_rdata  in  32  RAM combinational read data (RAM forwards same-cycle writes).
- mem_we  out  1  RAM write enable, one-cycle pulse.
- mem_waddr  out  ADDR_W  RAM write address, word aligned.
- mem_wdata  out  32  RAM write word.
- cdb_valid  out  1  load result valid.
- cdb_ready  in  1  CDB arbiter grant.
- cdb_tag  out  TAG_W  result tag.
- cdb_data  out  32  extended load data.
- cdb_exc  out  1  misaligned or illegal-funct3 load.
- st_done  out  1  one-cycle pulse when a store finishes or is rejected.
- st_tag  out  TAG_W  tag of the finished store.
- st_exc  out  1  store rejected (misaligned/illegal); no RAM write performed.

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready = 1 after reset release. Held request registers cleared.
- req_ready = (state==IDLE) && !flush. A request is captured at the accepting edge.
- States and transitions:
  - IDLE → LD_RD (load), ST_RD (sub-word store), ST_WR (word store), or ERR (misaligned/illegal).
  - LD_RD: mem_raddr = {addr[31:2],00}; capture extended data. → LD_RSP.
  - LD_RSP: cdb_valid = 1; tag/data/exc held stable until cdb_ready. On cdb_valid && cdb_ready → IDLE.
  - ST_RD: read the word; merge the byte/half lane into a registered word. → ST_WR.
  - ST_WR: mem_we = 1; mem_waddr = aligned addr; mem_wdata = merged word (or req_wdata for SW); st_done = 1. → IDLE.
  - ERR: a load goes to LD_RSP with cdb_exc = 1 and cdb_data = 0; a store pulses st_done with st_exc = 1. No RAM access in either case.
- Latency from the accept edge (cycle 0):
  - Load: mem_raddr in cycle 1; cdb_valid from cycle 2.
  - SW: mem_we in cycle 1.
  - SB/SH: read in cycle 1, mem_we in cycle 2.
- Misalignment rules: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0. Funct3 011, 110 and 111 are illegal. Stores with funct3 1xx are illegal.
- Lane select uses addr[1:0]; byte lane k = bits 8k+7:8k. B/H loads sign-extend; BU/HU zero-extend.
- mem_we is 0 in every state except ST_WR. mem_raddr/mem_waddr hold their last value otherwise.
- Flush handling:
  - In LD_RD or LD_RSP: → IDLE next edge, cdb_valid deasserted, result dropped.
  - Flush coincident with cdb_ready in LD_RSP: the handshake completes (the result already transferred).
  - ST_RD/ST_WR ignore flush.
- cdb_ready low in LD_RSP stalls indefinitely; req_ready stays 0.
- Reset mid-store aborts with no write; reset mid-load drops the result.

Decomposition:
- Shared package holds the funct3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW), the state enum, and TAG_W default.
- One natural sub-module: lsu_lane_align. It is combinational and provides:
  - load extract/extend (rdata, addr[1:0], funct3 → data);
  - store merge (old word, wdata, addr[1:0], funct3 → new word);
  - misalign/illegal detect.

Test Plan:
- RAM[0x100] = 0x8899AABB; LB @0x101 tag 3 → cdb_valid in cycle 2 with data 0xFFFFFFAA, tag 3. LBU @0x101 → 0x000000AA.
- SH wdata 0x1234 @0x102 on word 0x8899AABB → read cycle 1, mem_we cycle 2 with waddr 0x100, wdata 0x1234AABB, st_done = 1.
- SW 0xDEADBEEF @0x200 then immediate LW @0x200 → mem_we cycle 1; load returns 0xDEADBEEF; req_ready low during the store.
- LW @0x102 → cdb_exc = 1, data 0, no mem_we. SH @0x103 → st_exc = 1, no mem_we.
- LW accepted; cdb_ready held 0 for 5 cycles → data/tag stable and req_ready = 0; flush in cycle 4 → cdb_valid = 0 next cycle and IDLE.
- Assert rst asynchronously during ST_RD of SB → outputs zero immediately, no mem_we ever, req_ready = 1 after release.
